uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares the single `uart_transceiver` transmit path between NUM_REQ byte-stream requesters (status reporter, command echo, debug dump, ...).
- Frames are atomic: once a requester is granted, its bytes go out back-to-back until its `last` byte, with no interleaving from other requesters.
- Honours the AVR receive-buffer-full signal before issuing each byte.
- Recovers from a stuck transmitter or a stalled requester with a timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 50000, cycles allowed in HOLD or WAIT before the frame is aborted (must be greater than one byte time).
- TW, 16, timeout counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  8*NUM_REQ  packed bytes; requester i occupies bits [8i+7:8i]
- req_last  in  NUM_REQ  current byte is the final byte of its frame
- req_ready  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready)
- grant  out  NUM_REQ  one-hot owner of the TX path, all zero when idle
- tx_data  out  8  to transceiver tx_data
- tx_wr  out  1  one-cycle write strobe to transceiver
- tx_done  in  1  one-cycle pulse from transceiver, byte sent
- rx_busy  in  1  avr_rx_busy, asynchronous
- err_timeout  out  1  one-cycle pulse when a frame is aborted
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - grant=0, req_ready=0, tx_data=0, tx_wr=0, err_timeout=0, busy=0.
  - State IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first; timeout counter=0; rx_busy synchroniser flops=1 (treated as busy).
- rx_busy passes through a 2-flop synchroniser to give busy_s; only busy_s is used internally.
- States:
  - IDLE -> HOLD when any req_valid is high. The winner is the first set bit searching upward from rr_ptr+1 modulo NUM_REQ. grant is registered and appears the cycle after IDLE sees req_valid.
  - HOLD: req_ready[g] = (state==HOLD) & grant[g] & ~busy_s, combinational. On transfer: tx_data <= req_data[g], last_r <= req_last[g], tx_wr=1 on the next cycle for exactly one cycle, state -> WAIT. Counter clears on transfer.
  - WAIT: tx_wr low. On tx_done: if last_r, go to IDLE, clear grant, rr_ptr <= g; otherwise go back to HOLD. tx_done while in IDLE or HOLD is ignored.
  - Timeout: the counter increments every cycle in HOLD or WAIT. At TIMEOUT-1: err_timeout pulses, grant clears, rr_ptr <= g, state -> IDLE. The partial frame is dropped; the requester must restart it.
- busy_s high in HOLD: no req_ready is given and the counter keeps running.
- req_valid on a non-granted requester while busy has no effect; its ready stays 0.
- If the granted requester drops req_valid mid-frame, the scheduler waits in HOLD until the timeout.
- Latency, best case: req_valid in IDLE to tx_wr is 3 cycles (grant, transfer, strobe).
- Back-to-back frames: the IDLE cycle between frames is mandatory, so frames are separated by at least one cycle.
- Only one byte is in flight; the next req_ready comes no earlier than the cycle after tx_done.
- Reset asserted mid-frame returns to the reset values on the next edge; tx_wr is never left high.
- Simultaneous tx_done and timeout expiry: tx_done has priority, so the frame completes normally with no error.

Test Plan:
- Single frame: req_valid[0] with bytes 0x41,0x42 (last on 0x42), busy_s=0, tx_done model returns 10 cycles after tx_wr -> tx_wr at cycle 3, tx_data 0x41 then 0x42, grant=0001 for the whole frame, then grant=0, busy=0.
- Fairness: all four requesters hold one-byte frames continuously -> grant order 0,1,2,3,0,1, with exactly one tx_wr per grant.
- Atomicity: requester 2 sends a 3-byte frame while requester 1 asserts valid after byte 1 -> bytes from 2,2,2, then 1 is granted; req_ready[1]=0 throughout requester 2's frame.
- Flow control: rx_busy high for 100 cycles while requester 0 is in HOLD -> no req_ready and no tx_wr until 2 cycles after rx_busy falls, then normal transfer.
- Timeout: suppress tx_done after the first byte, TIMEOUT=200 -> err_timeout pulse exactly 200 cycles after entering WAIT, grant cleared, and the next requester in rotation is granted.
- Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0 next cycle; requester 0 is granted first afterwards even if requester 3 held the last grant.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmit path
// between NUM_REQ byte-stream requesters. A granted requester keeps the
// path until its last byte, one byte in flight at a time, gated by the
// synchronised AVR receive-busy flag, with a timeout to recover from a
// stuck transmitter or a stalled requester.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 50000,
    parameter int TW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    input  logic                 tx_done,
    input  logic                 rx_busy,
    output logic                 err_timeout,
    output logic                 busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_wr_q, tx_wr_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;
    logic [1:0]           sync_q, sync_d;

    logic                 busy_s;
    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic                 xfer;
    logic [7:0]           sel_data;
    logic                 sel_last;
    logic                 to_hit;

    // Requester index k steps after p, wrapping at NUM_REQ.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        return PW'((int'(p) + k) % NUM_REQ);
    endfunction

    assign busy_s    = sync_q[1];
    assign req_ready = (state_q == S_HOLD && !busy_s) ? grant_q : '0;
    assign xfer      = |(req_valid & req_ready);
    assign sel_data  = req_data[{gidx_q, 3'b000} +: 8];
    assign sel_last  = req_last[gidx_q];
    assign to_hit    = (cnt_q == TO_LAST);

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != S_IDLE);

    // Two-flop synchroniser for the asynchronous receive-busy flag.
    always_comb begin
        sync_d = {sync_q[0], rx_busy};
    end

    // Round-robin search: first valid requester above the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // Next-state logic: grant, byte transfer, completion and timeout abort.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        last_d    = last_q;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d = S_HOLD;
                    grant_d = NUM_REQ'(1) << win_idx;
                    gidx_d  = win_idx;
                end
            end
            S_HOLD: begin
                if (xfer) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    tx_wr_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end else if (to_hit) begin
                    err_d    = 1'b1;
                    grant_d  = '0;
                    rr_ptr_d = gidx_q;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // tx_done wins over an expiry landing on the same cycle.
                if (tx_done) begin
                    // A completed byte restarts the budget for the next one.
                    cnt_d = '0;
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = gidx_q;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (to_hit) begin
                    err_d    = 1'b1;
                    grant_d  = '0;
                    rr_ptr_d = gidx_q;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; the synchroniser resets to "busy" so nothing is
    // issued until the real rx_busy level has propagated.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= PTR_RST;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            sync_q    <= 2'b11;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            last_q    <= last_d;
            err_q     <= err_d;
            sync_q    <= sync_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: queue-based requester models, a
// transceiver model answering tx_wr with tx_done, and a scoreboard of
// expected (requester, byte) strobes checked by an independent monitor.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 200;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_wr;
    logic           tx_done;
    logic           rx_busy;
    logic           err_timeout;
    logic           busy;

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .TW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_done     (tx_done),
        .rx_busy     (rx_busy),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [8:0] mem [N][32];
    int         hd [N];
    int         tl [N];

    int   done_cnt = 0;
    logic suppress_done = 1'b0;

    int   n_wr = 0, n_to = 0, wr_cyc = 0, to_cyc = 0;
    logic prev_wr = 1'b0, rdy1_bad = 1'b0, stray_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_req(input int id, input logic [7:0] b, input logic l);
        mem[id][tl[id] % 32] = {l, b};
        tl[id]++;
    endtask

    task automatic expect_byte(input int id, input logic [7:0] b);
        exp_t x;
        x.id   = id;
        x.data = b;
        sb.push_back(x);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        req_valid = '0;
        done_cnt  = 0;
    endtask

    task automatic check_idle_outs(input string tag);
        chk({tag, "_grant"},     grant,       0);
        chk({tag, "_req_ready"}, req_ready,   0);
        chk({tag, "_tx_data"},   tx_data,     0);
        chk({tag, "_tx_wr"},     tx_wr,       0);
        chk({tag, "_err"},       err_timeout, 0);
        chk({tag, "_busy"},      busy,        0);
    endtask

    task automatic wait_wr(input int target, input int budget, input string name);
        int n = 0;
        while (n_wr < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n_wr >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int   n = 0;
        logic done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (sb.size() == 0) && !busy && (req_valid == '0);
            for (int i = 0; i < N; i++) if (hd[i] != tl[i]) done = 1'b0;
        end
        chk(name, done, 1);
    endtask

    // Requester models: present the head of each byte queue, pop on transfer.
    initial begin
        logic [N-1:0] xm;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < 32; j++) mem[i][j] = '0;
        forever begin
            @(negedge clk);
            xm = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (xm[i] && hd[i] != tl[i]) hd[i]++;
            for (int i = 0; i < N; i++) begin
                req_valid[i]        = (hd[i] != tl[i]);
                req_data[8*i +: 8]  = mem[i][hd[i] % 32][7:0];
                req_last[i]         = mem[i][hd[i] % 32][8];
            end
        end
    end

    // Transceiver model: one-cycle tx_done 10 cycles after each tx_wr.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) tx_done = 1'b1;
                end
                if (tx_wr && !suppress_done) done_cnt = 10;
            end
        end
    end

    // Monitor: compares every strobe against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_wr) begin
                n_wr++;
                wr_cyc = cyc;
                chk("tx_wr_single_cycle", prev_wr, 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx_wr: got data 0x%0h grant %b, want no strobe", tx_data, grant);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", tx_data, e.data);
                    chk("tx_grant", grant, 1 << e.id);
                end
            end
            prev_wr = tx_wr;
            if (err_timeout) begin
                n_to++;
                to_cyc = cyc;
                chk("grant_at_timeout", grant, 0);
            end
            if (grant[2] && req_ready[1]) rdy1_bad = 1'b1;
            if ((req_ready & ~grant) != '0) stray_rdy = 1'b1;
        end
    end

    // Hard stop if something hangs beyond all per-step budgets.
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish before %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int t0, n, base, base_to;
        logic bad;
        rx_busy = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame from requester 0: valid in cycle 1, strobe in cycle 3.
        push_req(0, 8'h41, 1'b0);
        push_req(0, 8'h42, 1'b1);
        expect_byte(0, 8'h41);
        expect_byte(0, 8'h42);
        n = 0;
        while (!req_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        t0   = cyc;
        base = n_wr;
        wait_wr(base + 1, 20, "single_first_strobe");
        chk("single_latency", wr_cyc - t0, 2);
        wait_idle(100, "single_idle");
        chk("single_grant_end", grant, 0);
        chk("single_busy_end", busy, 0);

        // Fairness: everyone continuously holds one-byte frames.
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        base = n_wr;
        for (int i = 0; i < N; i++) begin
            push_req(i, 8'h10 + 8'(i), 1'b1);
            push_req(i, 8'h20 + 8'(i), 1'b1);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) expect_byte(i, 8'h10 + 8'(16 * r) + 8'(i));
        wait_idle(600, "fair_idle");
        chk("fair_wr_count", n_wr - base, 8);

        // Atomicity: requester 1 arrives during requester 2's frame.
        rdy1_bad = 1'b0;
        base = n_wr;
        push_req(2, 8'hA0, 1'b0);
        push_req(2, 8'hA1, 1'b0);
        push_req(2, 8'hA2, 1'b1);
        expect_byte(2, 8'hA0);
        expect_byte(2, 8'hA1);
        expect_byte(2, 8'hA2);
        wait_wr(base + 1, 50, "atomic_first_strobe");
        push_req(1, 8'hB0, 1'b1);
        expect_byte(1, 8'hB0);
        wait_idle(300, "atomic_idle");
        chk("atomic_ready1_during_2", rdy1_bad, 0);

        // Flow control: rx_busy high for 100 cycles with requester 0 in HOLD.
        @(negedge clk);
        rx_busy = 1'b1;
        push_req(0, 8'h55, 1'b1);
        expect_byte(0, 8'h55);
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (req_ready != '0 || tx_wr) bad = 1'b1;
        end
        chk("flow_no_ready_while_busy", bad, 0);
        chk("flow_grant_held", grant, 4'b0001);
        rx_busy = 1'b0;
        n = 0;
        while (!req_ready[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("flow_ready_delay", n, 2);
        wait_idle(100, "flow_idle");

        // Timeout: first byte of requester 1 never completes.
        chk("no_timeout_before", n_to, 0);
        suppress_done = 1'b1;
        base    = n_wr;
        base_to = n_to;
        push_req(1, 8'h61, 1'b0);
        push_req(1, 8'h62, 1'b1);
        push_req(2, 8'h71, 1'b1);
        expect_byte(1, 8'h61);
        expect_byte(2, 8'h71);
        expect_byte(1, 8'h62);
        wait_wr(base + 1, 50, "timeout_first_strobe");
        n = 0;
        while (n_to == base_to && n < 300) begin
            @(negedge clk);
            n++;
        end
        suppress_done = 1'b0;
        chk("timeout_seen", (n_to > base_to), 1);
        chk("timeout_latency", to_cyc - wr_cyc, TO);
        @(negedge clk);
        chk("grant_after_timeout", grant, 4'b0100);
        wait_idle(300, "timeout_idle");
        chk("timeout_count", n_to - base_to, 1);

        // Reset mid-WAIT while requester 3 owns the path.
        base = n_wr;
        push_req(3, 8'h33, 1'b0);
        push_req(3, 8'h34, 1'b1);
        expect_byte(3, 8'h33);
        wait_wr(base + 1, 50, "midrst_first_strobe");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        check_idle_outs("midrst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push_req(3, 8'h3A, 1'b1);
        push_req(0, 8'h0A, 1'b1);
        expect_byte(0, 8'h0A);
        expect_byte(3, 8'h3A);
        wait_idle(200, "midrst_idle");

        chk("scoreboard_drained", sb.size(), 0);
        chk("no_stray_ready", stray_rdy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
